// File: rtl/idx_onehot_dispatch_pkg.sv
// idx_onehot_dispatch_pkg: shared defaults and index-width helper for the dispatcher
package idx_onehot_dispatch_pkg;

    localparam int DEF_N          = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/idx_onehot_dispatch_if.sv
// idx_onehot_dispatch_if: upstream indexed beat plus one-hot downstream bus
interface idx_onehot_dispatch_if
    import idx_onehot_dispatch_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
);
    localparam int LOG_N_INP = idx_width(N);

    logic [LOG_N_INP-1:0]  idx_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  valid_i;
    logic                  ready_o;
    logic [N-1:0]          valid_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic [N-1:0]          ready_i;
    logic                  err_o;
    logic [CNT_WIDTH-1:0]  cnt_o;
    logic                  busy_o;

    modport slave (
        input  idx_i, data_i, valid_i, ready_i,
        output ready_o, valid_o, data_o, err_o, cnt_o, busy_o
    );

    modport master (
        output idx_i, data_i, valid_i, ready_i,
        input  ready_o, valid_o, data_o, err_o, cnt_o, busy_o
    );

endinterface

// File: rtl/idx_onehot_dispatch_idx_to_onehot.sv
// idx_to_onehot: index to N-bit one-hot decoder; in_range is low for idx >= N
module idx_to_onehot #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [W-1:0] idx,
    output logic [N-1:0] onehot,
    output logic         in_range
);

    always_comb begin
        onehot = '0;
        for (int k = 0; k < N; k++) onehot[k] = (idx == W'(k));
        in_range = |onehot;
    end

endmodule

// File: rtl/idx_onehot_dispatch.sv
// idx_onehot_dispatch: registered index-to-one-hot router with valid/ready on both sides
module idx_onehot_dispatch
    import idx_onehot_dispatch_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int LOG_N_INP  = idx_width(N)
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    idx_onehot_dispatch_if.slave bus
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                state_q, state_d;
    logic [LOG_N_INP-1:0]  sel_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [N-1:0]          in_oh, sel_oh;
    logic                  in_legal, sel_legal;
    logic                  drain, ready, accept, take, drop;

    idx_to_onehot #(.N(N), .W(LOG_N_INP)) u_in_dec (
        .idx      (bus.idx_i),
        .onehot   (in_oh),
        .in_range (in_legal)
    );

    idx_to_onehot #(.N(N), .W(LOG_N_INP)) u_sel_dec (
        .idx      (sel_q),
        .onehot   (sel_oh),
        .in_range (sel_legal)
    );

    // Masking ready_i with the decoded sel ignores every non-target ready bit
    always_comb begin
        drain   = (state_q == FULL) && |(sel_oh & bus.ready_i);
        ready   = (state_q == EMPTY) || drain;
        accept  = bus.valid_i && ready;
        take    = accept && in_legal;
        drop    = accept && !in_legal;
        state_d = take ? FULL : drain ? EMPTY : state_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            sel_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= drop;
            if (take) begin
                sel_q  <= bus.idx_i;
                data_q <= bus.data_i;
            end
            if (drain) cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign bus.ready_o = ready;
    assign bus.valid_o = (state_q == FULL && sel_legal) ? sel_oh : '0;
    assign bus.data_o  = data_q;
    assign bus.err_o   = err_q;
    assign bus.cnt_o   = cnt_q;
    assign bus.busy_o  = (state_q == FULL);

    // in_oh is only needed for its in-range flag
    logic unused_in_oh;
    assign unused_in_oh = ^in_oh;

endmodule

// File: tb/tb_idx_onehot_dispatch.sv
// tb_idx_onehot_dispatch: scoreboard bench for N=4 (16- and 4-bit counters) plus directed N=3 checks
module tb_idx_onehot_dispatch;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    idx_onehot_dispatch_if #(.N(4), .DATA_WIDTH(32), .CNT_WIDTH(16)) a_if ();
    idx_onehot_dispatch_if #(.N(4), .DATA_WIDTH(32), .CNT_WIDTH(4))  c_if ();
    idx_onehot_dispatch_if #(.N(3), .DATA_WIDTH(32), .CNT_WIDTH(16)) b_if ();

    idx_onehot_dispatch #(.N(4), .DATA_WIDTH(32), .CNT_WIDTH(16)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(a_if.slave));
    idx_onehot_dispatch #(.N(4), .DATA_WIDTH(32), .CNT_WIDTH(4)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .bus(c_if.slave));
    idx_onehot_dispatch #(.N(3), .DATA_WIDTH(32), .CNT_WIDTH(16)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(b_if.slave));

    assign c_if.idx_i   = a_if.idx_i;
    assign c_if.data_i  = a_if.data_i;
    assign c_if.valid_i = a_if.valid_i;
    assign c_if.ready_i = a_if.ready_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    typedef struct {
        logic [1:0]  idx;
        logic [31:0] data;
    } beat_t;

    beat_t q[$];
    int    m_cnt = 0;
    bit    armed = 0;

    // Scoreboard: accepted beats queue up, the held beat is popped when its target drains
    always @(negedge clk) begin
        logic [3:0] ev;
        logic       er, drn, acc;
        if (!rst_n) begin
            q.delete();
            m_cnt = 0;
            armed = 1;
        end else if (armed) begin
            ev  = (q.size() != 0) ? (4'b0001 << q[0].idx) : 4'b0000;
            er  = (q.size() == 0) || a_if.ready_i[q[0].idx];
            chk("valid_o", 32'(a_if.valid_o), 32'(ev));
            chk("busy_o", 32'(a_if.busy_o), 32'(q.size() != 0));
            chk("ready_o", 32'(a_if.ready_o), 32'(er));
            chk("err_o", 32'(a_if.err_o), 32'd0);
            chk("cnt_o", 32'(a_if.cnt_o), m_cnt & 32'hffff);
            chk("cnt4_o", 32'(c_if.cnt_o), m_cnt & 32'hf);
            chk("valid4_o", 32'(c_if.valid_o), 32'(ev));
            if (q.size() != 0) chk("data_o", a_if.data_o, q[0].data);
            drn = (q.size() != 0) && a_if.ready_i[q[0].idx];
            acc = a_if.valid_i && er;
            if (drn) begin
                void'(q.pop_front());
                m_cnt++;
            end
            if (acc) q.push_back('{a_if.idx_i, a_if.data_i});
        end
    end

    initial begin
        rst_n = 1'b0;
        a_if.idx_i = '0; a_if.data_i = '0; a_if.valid_i = 1'b0; a_if.ready_i = '0;
        b_if.idx_i = '0; b_if.data_i = '0; b_if.valid_i = 1'b0; b_if.ready_i = '0;
        step(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_data_o", a_if.data_o, 32'd0);
        chk("rst_ready_o", 32'(a_if.ready_o), 32'd1);
        step(1);
        // single beat to destination 2
        a_if.idx_i = 2; a_if.data_i = 32'hA5A5_0002; a_if.valid_i = 1'b1; a_if.ready_i = 4'b0100;
        step(1);
        a_if.valid_i = 1'b0;
        step(3);
        // back-to-back stream, one beat per cycle
        a_if.ready_i = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            a_if.idx_i = 2'(i); a_if.data_i = 32'h1000_0000 + i; a_if.valid_i = 1'b1;
            step(1);
        end
        a_if.valid_i = 1'b0;
        step(2);
        // backpressure on destination 1 while others are ready, next beat waiting
        a_if.ready_i = 4'b1101;
        a_if.idx_i = 1; a_if.data_i = 32'hB1B1_0001; a_if.valid_i = 1'b1;
        step(1);
        a_if.idx_i = 3; a_if.data_i = 32'hC3C3_0003;
        step(5);
        a_if.ready_i = 4'b1111;
        step(1);
        a_if.valid_i = 1'b0;
        step(2);
        // reset while a beat to destination 3 is held
        a_if.ready_i = 4'b0000;
        a_if.idx_i = 3; a_if.data_i = 32'hDEAD_0003; a_if.valid_i = 1'b1;
        step(1);
        a_if.valid_i = 1'b0;
        step(2);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid_o", 32'(a_if.valid_o), 32'd0);
        chk("post_rst_busy_o", 32'(a_if.busy_o), 32'd0);
        chk("post_rst_cnt_o", 32'(a_if.cnt_o), 32'd0);
        step(1);
        // 17 beats: the 4-bit counter passes 15 -> 0 -> 1
        a_if.ready_i = 4'b1111;
        for (int i = 0; i < 17; i++) begin
            a_if.idx_i = 2'(i); a_if.data_i = 32'h2000_0000 + i; a_if.valid_i = 1'b1;
            step(1);
        end
        a_if.valid_i = 1'b0;
        step(2);
        @(negedge clk);
        chk("cnt4_wrap", 32'(c_if.cnt_o), 32'd1);
        step(1);
        // random traffic
        for (int i = 0; i < 200; i++) begin
            a_if.idx_i = 2'($urandom_range(0, 3));
            a_if.data_i = $urandom;
            a_if.valid_i = 1'($urandom_range(0, 1));
            a_if.ready_i = 4'($urandom);
            step(1);
        end
        a_if.valid_i = 1'b0;
        a_if.ready_i = 4'b1111;
        step(3);
        // N=3: illegal index 3 is accepted and dropped with a one-cycle error
        b_if.idx_i = 3; b_if.data_i = 32'hEEEE_0003; b_if.valid_i = 1'b1; b_if.ready_i = 3'b000;
        @(negedge clk);
        chk("n3_ready_o", 32'(b_if.ready_o), 32'd1);
        chk("n3_err_pre", 32'(b_if.err_o), 32'd0);
        step(1);
        b_if.valid_i = 1'b0;
        @(negedge clk);
        chk("n3_err_o", 32'(b_if.err_o), 32'd1);
        chk("n3_valid_o", 32'(b_if.valid_o), 32'd0);
        chk("n3_busy_o", 32'(b_if.busy_o), 32'd0);
        chk("n3_cnt_o", 32'(b_if.cnt_o), 32'd0);
        step(1);
        @(negedge clk);
        chk("n3_err_clr", 32'(b_if.err_o), 32'd0);
        // legal beat to 2, then drain plus illegal accept in one cycle
        b_if.idx_i = 2; b_if.data_i = 32'h3333_0002; b_if.valid_i = 1'b1;
        step(1);
        @(negedge clk);
        chk("n3_valid_2", 32'(b_if.valid_o), 32'd4);
        chk("n3_data_2", b_if.data_o, 32'h3333_0002);
        b_if.idx_i = 3; b_if.ready_i = 3'b100;
        step(1);
        b_if.valid_i = 1'b0;
        @(negedge clk);
        chk("n3_drop_err", 32'(b_if.err_o), 32'd1);
        chk("n3_drop_busy", 32'(b_if.busy_o), 32'd0);
        chk("n3_drop_valid", 32'(b_if.valid_o), 32'd0);
        chk("n3_drop_cnt", 32'(b_if.cnt_o), 32'd1);
        step(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
